reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin arbiter that shares one DATAWIDTH-bit datapath register among NREQ requesting units. It accepts write requests, grants exactly one requester at a time, and commits that requester's data into the shared register. It returns a one-cycle acknowledge to the winner. It sits between the scheduled datapath units and the shared storage register, which it owns.

## Interface
- DATAWIDTH, 16, width of the shared register and of each requester's data lane
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of the requester index
- Clk  input  1  clock, all logic on rising edge
- Rst  input  1  reset, synchronous, active-high
- Req  input  NREQ  per-requester write request; bit i belongs to requester i
- Din  input  NREQ*DATAWIDTH  packed data lanes; lane i is Din[i*DATAWIDTH +: DATAWIDTH]
- Gnt  output  NREQ  registered one-hot grant; all zero when nothing is granted
- Ack  output  1  one-cycle pulse; the write has been committed to Q
- AckId  output  IDW  index of the committed requester; valid while Ack=1
- Busy  output  1  high in GRANT and COMMIT
- Q  output  DATAWIDTH  shared register contents

## Operation
- Reset: applies on any Clk edge with Rst=1 and overrides everything.
  - State goes to IDLE.
  - Q, Gnt, Ack, AckId and Busy all go to 0; every bit of Q is cleared.
  - The last-winner pointer Last goes to NREQ-1, so requester 0 has top priority after reset.
- Reset mid-operation: in GRANT or COMMIT, state returns to IDLE and no commit happens. If Rst coincides with the GRANT->COMMIT edge, Q clears and Ack stays 0.
- FSM states: IDLE, GRANT, COMMIT.
- IDLE:
  - If Req=0, stay in IDLE.
  - Otherwise pick winner w, the first set bit of Req scanning from index Last+1 upward with wrap at NREQ.
  - Register Gnt <= onehot(w) and go to GRANT.
- GRANT (Gnt=onehot(w), Busy=1):
  - If Req[w]=1 at the edge: Q <= Din lane w, Last <= w, AckId <= w, Ack <= 1, Gnt <= 0, go to COMMIT.
  - If Req[w]=0 at the edge (requester withdrew): abort. Gnt <= 0 and go to IDLE; Q, Last and Ack are unchanged.
  - Requests from other requesters are ignored in this state.
- COMMIT (Ack=1, Busy=1, Gnt=0):
  - Ack <= 0 and go to IDLE unconditionally.
- Requester protocol:
  - Hold Req and Din stable from assertion until Ack.
  - Deassert Req in the cycle after Ack unless it wants another write.
  - If Req is still high in IDLE, it is re-arbitrated with its priority now lowest.
- Fairness: after a requester wins, it has the lowest priority. A requester that holds Req continuously is granted within NREQ arbitrations.
- Only a commit moves Last; an abort does not.
- Q changes only on a commit or on reset.

## Timing
- Req sampled high in IDLE at edge k:
  - Gnt is high during cycle k..k+1.
  - Q updates and Ack rises at edge k+1.
  - Ack falls at edge k+2.
  - State is IDLE again after edge k+2.
- Minimum spacing between commits is 3 cycles; peak throughput is 1 write per 3 cycles.
- Gnt, Ack, AckId, Busy and Q are all registered. There is no combinational path from an input to an output.
- Din is sampled only at the GRANT->COMMIT edge.

## Test plan
- Reset:
  - Stimulus: hold Rst=1 for 2 cycles with Req=4'b1111 and arbitrary Din.
  - Required: Q=0, Gnt=0, Ack=0, Busy=0 throughout; requester 0 is granted first after Rst drops.
- Single writer:
  - Stimulus: Req=4'b0100 with lane 2 = 16'hBEEF, held until Ack.
  - Required: Gnt=4'b0100 for one cycle, then Ack=1 with AckId=2 and Q=16'hBEEF on the same edge.
- Contention:
  - Stimulus: Req=4'b1111 held continuously, lane i = 16'h1000+i.
  - Required: commits in order AckId 0,1,2,3,0, 3 cycles apart; Q tracks 16'h1000..16'h1003.
- Round-robin fairness:
  - Stimulus: after requester 1 commits, assert Req=4'b0011.
  - Required: requester 0 is granted before requester 1.
- Abort:
  - Stimulus: requester 3 drops Req during GRANT.
  - Required: no Ack and Q unchanged. The next arbitration starts from the old Last, so with Last=2 and Req=4'b1001, requester 3 wins.
- Reset mid-operation:
  - Stimulus: assert Rst during GRANT with Q=16'h00FF.
  - Required: next cycle IDLE, Q=0, Gnt=0, Ack never pulses.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that commits one requester's data lane into a shared register
module reg_write_arbiter #(
  parameter int DATAWIDTH = 16,
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*DATAWIDTH-1:0] Din,
  output logic [NREQ-1:0]           Gnt,
  output logic                      Ack,
  output logic [IDW-1:0]            AckId,
  output logic                      Busy,
  output logic [DATAWIDTH-1:0]      Q
);
  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;
  state_t state;
  logic [IDW-1:0] last, cur, win, idx;
  logic [DATAWIDTH-1:0] lanes [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lanes[g] = Din[g*DATAWIDTH +: DATAWIDTH];
  end
  // scan downward so the closest set bit after last is the final assignment
  always_comb begin
    win = last;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % NREQ);
      win = Req[idx] ? idx : win;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      Q     <= '0;
      Gnt   <= '0;
      Ack   <= 1'b0;
      AckId <= '0;
      Busy  <= 1'b0;
      last  <= IDW'(NREQ - 1);
      cur   <= '0;
    end else begin
      case (state)
        IDLE: if (|Req) begin
          cur   <= win;
          Gnt   <= NREQ'(1) << win;
          Busy  <= 1'b1;
          state <= GRANT;
        end
        GRANT: begin
          Gnt <= '0;
          if (Req[cur]) begin
            Q     <= lanes[cur];
            last  <= cur;
            AckId <= cur;
            Ack   <= 1'b1;
            state <= COMMIT;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        COMMIT: begin
          Ack   <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
